tinyqv_periph_initiator: RTL and testbench

Bus initiator for the TinyQV peripheral interface. It is the core-side counterpart to our peripherals, such as the CORDIC wrapper. It accepts single read and write commands on a valid/ready command port and drives `address`, `data_write_n`, `data_read_n` and write data, then waits for `data_ready`. It returns read data or completion on a valid/ready response port. It is used in the standalone peripheral test harness and the FPGA bring-up shell, where no TinyQV core is present.

---
 rtl/tinyqv_periph_initiator.sv | 235 +++++++++++++++++++++++
 tb/tb_tinyqv_periph_initiator.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tinyqv_periph_initiator.sv
// TinyQV peripheral bus initiator.
// Turns single read/write commands from a valid/ready command port into
// TinyQV peripheral bus cycles, then returns the read data or a completion
// on a valid/ready response port. It stands in for the TinyQV core in the
// standalone peripheral harness and in the FPGA bring-up shell.
//
// Timing, counting from the command accept edge T:
//   read   : data_read_n = size from T+1 and held through the cycle in
//            which data_ready is sampled high; the response appears on the
//            edge after that.
//   write  : data_write_n = size for exactly one cycle (T+1). Without
//            cmd_wait the response appears at T+2. With cmd_wait the
//            initiator waits for data_ready, and captures data_in so that
//            accelerator results come back in rsp_rdata.
//   timeout: the cycle counter is 0 in the first READ/WAIT cycle. If it
//            reaches TIMEOUT while data_ready is still low, the bus is
//            released and an error response is raised on the next edge.
//            For a read this means TIMEOUT wait cycles after the strobe
//            cycle. data_ready in that same cycle still counts as success.
module tinyqv_periph_initiator #(
   parameter int unsigned TIMEOUT = 256,
   parameter int unsigned CNT_W   = 9
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic        cmd_wait,
   input  logic [1:0]  cmd_size,
   input  logic [5:0]  cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [5:0]  address,
   output logic [31:0] data_out,
   output logic [1:0]  data_write_n,
   output logic [1:0]  data_read_n,
   input  logic [31:0] data_in,
   input  logic        data_ready
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WRITE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_READ  = 3'd3;
   localparam logic [2:0] S_RESP  = 3'd4;

   localparam logic [1:0]       BUS_IDLE    = 2'b11;
   localparam logic [1:0]       SIZE_ILLEGAL = 2'b11;
   localparam logic             TIMEOUT_EN  = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = TIMEOUT[CNT_W-1:0];
   localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       size_q, size_d;
   logic             wait_q, wait_d;
   logic             cmd_ready_q, cmd_ready_d;
   logic [5:0]       address_q, address_d;
   logic [31:0]      data_out_q, data_out_d;
   logic [1:0]       data_write_n_q, data_write_n_d;
   logic [1:0]       data_read_n_q, data_read_n_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [31:0]      rsp_rdata_q, rsp_rdata_d;
   logic             rsp_err_q, rsp_err_d;
   logic             timeout_hit;

   // Zero-extend peripheral read data to the transfer size.
   function automatic logic [31:0] mask_to_size(input logic [31:0] d,
                                                input logic [1:0]  sz);
      logic [31:0] m;
      case (sz)
         2'b00:   m = {24'h000000, d[7:0]};
         2'b01:   m = {16'h0000, d[15:0]};
         default: m = d;
      endcase
      return m;
   endfunction

   assign timeout_hit = TIMEOUT_EN && (cnt_q == TIMEOUT_CNT);

   // Next-state logic: command accept, bus strobes, completion and timeout.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      size_d         = size_q;
      wait_d         = wait_q;
      address_d      = address_q;
      data_out_d     = data_out_q;
      data_write_n_d = data_write_n_q;
      data_read_n_d  = data_read_n_q;
      rsp_valid_d    = rsp_valid_q;
      rsp_rdata_d    = rsp_rdata_q;
      rsp_err_d      = rsp_err_q;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               address_d  = cmd_addr;
               data_out_d = cmd_wdata;
               size_d     = cmd_size;
               wait_d     = cmd_write & cmd_wait;
               if (cmd_size == SIZE_ILLEGAL) begin
                  // Illegal size never reaches the bus.
                  state_d     = S_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = 32'h0;
               end else if (cmd_write) begin
                  data_write_n_d = cmd_size;
                  state_d        = S_WRITE;
               end else begin
                  data_read_n_d = cmd_size;
                  cnt_d         = '0;
                  state_d       = S_READ;
               end
            end
         end

         S_WRITE: begin
            // The write strobe is a single-cycle pulse.
            data_write_n_d = BUS_IDLE;
            if (!wait_q) begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = 32'h0;
            end else if (data_ready) begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = data_in;
            end else begin
               cnt_d   = '0;
               state_d = S_WAIT;
            end
         end

         S_READ: begin
            if (data_ready) begin
               data_read_n_d = BUS_IDLE;
               state_d       = S_RESP;
               rsp_valid_d   = 1'b1;
               rsp_err_d     = 1'b0;
               rsp_rdata_d   = mask_to_size(data_in, size_q);
            end else if (timeout_hit) begin
               data_read_n_d = BUS_IDLE;
               state_d       = S_RESP;
               rsp_valid_d   = 1'b1;
               rsp_err_d     = 1'b1;
               rsp_rdata_d   = 32'h0;
            end else if (TIMEOUT_EN) begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         S_WAIT: begin
            if (data_ready) begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = data_in;
            end else if (timeout_hit) begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = 32'h0;
            end else if (TIMEOUT_EN) begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end

         default: begin
            state_d        = S_IDLE;
            data_write_n_d = BUS_IDLE;
            data_read_n_d  = BUS_IDLE;
            rsp_valid_d    = 1'b0;
         end
      endcase

      // cmd_ready is registered, so it reflects the state being entered.
      cmd_ready_d = (state_d == S_IDLE);
   end

   // State and output registers; reset abandons any transaction in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         size_q         <= 2'b00;
         wait_q         <= 1'b0;
         cmd_ready_q    <= 1'b1;
         address_q      <= 6'h00;
         data_out_q     <= 32'h0;
         data_write_n_q <= BUS_IDLE;
         data_read_n_q  <= BUS_IDLE;
         rsp_valid_q    <= 1'b0;
         rsp_rdata_q    <= 32'h0;
         rsp_err_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         size_q         <= size_d;
         wait_q         <= wait_d;
         cmd_ready_q    <= cmd_ready_d;
         address_q      <= address_d;
         data_out_q     <= data_out_d;
         data_write_n_q <= data_write_n_d;
         data_read_n_q  <= data_read_n_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_rdata_q    <= rsp_rdata_d;
         rsp_err_q      <= rsp_err_d;
      end
   end

   assign cmd_ready    = cmd_ready_q;
   assign address      = address_q;
   assign data_out     = data_out_q;
   assign data_write_n = data_write_n_q;
   assign data_read_n  = data_read_n_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_rdata    = rsp_rdata_q;
   assign rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_tinyqv_periph_initiator.sv
// Testbench for tinyqv_periph_initiator: directed commands, with a
// scoreboard queue of expected responses drained by a response monitor.
module tb_tinyqv_periph_initiator;

   localparam int TO = 24;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid, cmd_write, cmd_wait;
   logic        cmd_ready;
   logic [1:0]  cmd_size;
   logic [5:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic [5:0]  address;
   logic [31:0] data_out;
   logic [1:0]  data_write_n, data_read_n;
   logic [31:0] data_in;
   logic        data_ready;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   rsp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   logic        hold_pend = 1'b0;
   logic [31:0] hold_rdata;
   logic        hold_err;

   tinyqv_periph_initiator #(.TIMEOUT(TO), .CNT_W(9)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_wait(cmd_wait), .cmd_size(cmd_size), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err),
      .address(address), .data_out(data_out), .data_write_n(data_write_n),
      .data_read_n(data_read_n), .data_in(data_in), .data_ready(data_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Response monitor: stability while stalled, then scoreboard compare.
   always @(negedge clk) begin
      if (reset) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            check("rsp_hold_valid", {31'b0, rsp_valid}, 32'd1);
            check("rsp_hold_rdata", rsp_rdata, hold_rdata);
            check("rsp_hold_err", {31'b0, rsp_err}, {31'b0, hold_err});
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rsp_unexpected: got rdata %h err %b, required no response",
                        rsp_rdata, rsp_err);
            end else begin
               rsp_t e;
               e = exp_q.pop_front();
               check("rsp_rdata", rsp_rdata, e.rdata);
               check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
            end
         end
         hold_pend  = rsp_valid && !rsp_ready;
         hold_rdata = rsp_rdata;
         hold_err   = rsp_err;
      end
   end

   // Present one command and hold it until the accept edge.
   task automatic issue(input logic wr, input logic wt, input logic [1:0] sz,
                        input logic [5:0] a, input logic [31:0] wd);
      int n;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!cmd_ready) check("issue_cmd_ready", {31'b0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1; cmd_write = wr; cmd_wait = wt;
      cmd_size  = sz;   cmd_addr  = a;  cmd_wdata = wd;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   // Peripheral side, cycle 0 = first cycle after the accept edge.
   task automatic run_bus(input int ready_at, input logic [31:0] din,
                          output int low_rd, output int low_wr, output int lat);
      low_rd = 0; low_wr = 0; lat = -1;
      data_in = din;
      for (int c = 0; c < 80; c++) begin
         if (rsp_valid) begin
            lat = c;
            break;
         end
         if (data_read_n != 2'b11) low_rd++;
         if (data_write_n != 2'b11) low_wr++;
         data_ready = (c == ready_at);
         @(posedge clk); #1;
      end
      data_ready = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_idle"}, {31'b0, cmd_ready}, 32'd1);
      check({name, "_bus_rd_idle"}, {30'b0, data_read_n}, 32'd3);
      check({name, "_bus_wr_idle"}, {30'b0, data_write_n}, 32'd3);
   endtask

   task automatic do_txn(input string name, input logic wr, input logic wt,
                         input logic [1:0] sz, input logic [5:0] a,
                         input logic [31:0] wd, input int ready_at,
                         input logic [31:0] din, input logic [31:0] exp_rdata,
                         input logic exp_err, input int exp_lat,
                         input int exp_rd, input int exp_wr);
      int lrd, lwr, lat;
      exp_q.push_back('{rdata: exp_rdata, err: exp_err});
      issue(wr, wt, sz, a, wd);
      check({name, "_address"}, {26'b0, address}, {26'b0, a});
      check({name, "_data_out"}, data_out, wd);
      run_bus(ready_at, din, lrd, lwr, lat);
      check({name, "_lat"}, lat, exp_lat);
      check({name, "_rd_cycles"}, lrd, exp_rd);
      check({name, "_wr_cycles"}, lwr, exp_wr);
      wait_idle(name);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, required $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lrd, lwr, lat;
      reset = 1'b1; rsp_ready = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_wait = 1'b0;
      cmd_size = 2'b00; cmd_addr = 6'h00; cmd_wdata = 32'h0;
      data_in = 32'h0; data_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;

      // Reset values
      check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
      check("rst_write_n", {30'b0, data_write_n}, 32'd3);
      check("rst_read_n", {30'b0, data_read_n}, 32'd3);
      check("rst_address", {26'b0, address}, 32'd0);
      check("rst_data_out", data_out, 32'd0);
      check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);

      // Reads: 32b with ready 3 cycles after strobe, then 8b / 16b masking
      do_txn("rd32", 0, 0, 2'b10, 6'h04, 32'h0, 3, 32'hDEADBEEF,
             32'hDEADBEEF, 0, 4, 4, 0);
      do_txn("rd8", 0, 0, 2'b00, 6'h3F, 32'h0, 0, 32'h123456A5,
             32'h000000A5, 0, 1, 1, 0);
      do_txn("rd16", 0, 0, 2'b01, 6'h3F, 32'h0, 1, 32'h123456A5,
             32'h000056A5, 0, 2, 2, 0);

      // Writes: accelerator start waits for data_ready, plain write does not
      do_txn("wr_wait", 1, 1, 2'b10, 6'h00, 32'h40000000, 20, 32'h5A82799A,
             32'h5A82799A, 0, 21, 0, 1);
      do_txn("wr_nowait", 1, 0, 2'b10, 6'h00, 32'h40000000, -1, 32'h5A82799A,
             32'h00000000, 0, 1, 0, 1);
      do_txn("wr_rdy_in_write", 1, 1, 2'b01, 6'h11, 32'h0000BEEF, 0, 32'h00C0FFEE,
             32'h00C0FFEE, 0, 1, 0, 1);

      // Timeouts and the same-cycle priority of data_ready
      do_txn("rd_timeout", 0, 0, 2'b10, 6'h08, 32'h0, -1, 32'hFFFFFFFF,
             32'h00000000, 1, TO + 1, TO + 1, 0);
      do_txn("rd_ready_at_to", 0, 0, 2'b10, 6'h08, 32'h0, TO, 32'h13579BDF,
             32'h13579BDF, 0, TO + 1, TO + 1, 0);
      do_txn("wait_timeout", 1, 1, 2'b10, 6'h09, 32'h00000001, -1, 32'hFFFFFFFF,
             32'h00000000, 1, TO + 2, 0, 1);

      // Illegal size: no bus activity, error response
      do_txn("rd_size11", 0, 0, 2'b11, 6'h15, 32'h0, 0, 32'hAAAA5555,
             32'h00000000, 1, 0, 0, 0);
      do_txn("wr_size11", 1, 1, 2'b11, 6'h16, 32'h87654321, 0, 32'hAAAA5555,
             32'h00000000, 1, 0, 0, 0);

      // Back-to-back commands with the response stalled for 5 cycles
      rsp_ready = 1'b0;
      exp_q.push_back('{rdata: 32'h0000F00D, err: 1'b0});
      issue(0, 0, 2'b01, 6'h01, 32'h0);
      run_bus(0, 32'hCAFEF00D, lrd, lwr, lat);
      check("b2b_first_lat", lat, 1);
      exp_q.push_back('{rdata: 32'h00000000, err: 1'b0});
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_wait = 1'b0;
      cmd_size = 2'b10; cmd_addr = 6'h02; cmd_wdata = 32'h11223344;
      for (int i = 0; i < 5; i++) begin
         check("b2b_stall_cmd_ready", {31'b0, cmd_ready}, 32'd0);
         check("b2b_stall_no_strobe", {30'b0, data_write_n}, 32'd3);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("b2b_ready_after_hs", {31'b0, cmd_ready}, 32'd1);
      check("b2b_valid_after_hs", {31'b0, rsp_valid}, 32'd0);
      check("b2b_no_accept_in_hs", {30'b0, data_write_n}, 32'd3);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check("b2b_second_strobe", {30'b0, data_write_n}, 32'd2);
      check("b2b_second_addr", {26'b0, address}, 32'd2);
      run_bus(-1, 32'h0, lrd, lwr, lat);
      check("b2b_second_lat", lat, 1);
      wait_idle("b2b");

      // Reset in the middle of a read: bus released, no response
      issue(0, 0, 2'b10, 6'h05, 32'h0);
      check("rstmid_strobe", {30'b0, data_read_n}, 32'd2);
      repeat (3) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      check("rstmid_read_n", {30'b0, data_read_n}, 32'd3);
      check("rstmid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rstmid_cmd_ready", {31'b0, cmd_ready}, 32'd1);
      check("rstmid_address", {26'b0, address}, 32'd0);
      reset = 1'b0;
      data_ready = 1'b1;
      data_in = 32'h99999999;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("rstmid_quiet_valid", {31'b0, rsp_valid}, 32'd0);
      end
      data_ready = 1'b0;
      do_txn("after_rst", 0, 0, 2'b00, 6'h2A, 32'h0, 2, 32'h0000007E,
             32'h0000007E, 0, 3, 3, 0);

      repeat (3) @(posedge clk);
      #1;
      check("sb_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
